// File: rtl/log_capture_pkg.sv
// rtl/log_capture_pkg.sv - shared FSM encoding and default parameters for the log capture controller
package log_capture_pkg;

    localparam int NBT_DATA_DEF  = 32;
    localparam int NUM_CH_DEF    = 4;
    localparam int RAM_DEPTH_DEF = 32768;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // True while a capture is in progress (samples may be written).
    function automatic logic is_capturing(input state_t s);
        return (s == PRE) || (s == ARMED) || (s == POST);
    endfunction

endpackage

// File: rtl/log_capture_ctrl_if.sv
// rtl/log_capture_ctrl_if.sv - sample stream and read port bundle of the log capture controller
interface log_capture_ctrl_if
    import log_capture_pkg::*;
#(
    parameter int NBT_DATA  = NBT_DATA_DEF,
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int RAM_DEPTH = RAM_DEPTH_DEF
);
    logic [NUM_CH*NBT_DATA-1:0]    i_ch_data;
    logic                          i_ch_valid;
    logic                          i_rd_en;
    logic [$clog2(RAM_DEPTH)-1:0]  i_rd_adrs;
    logic [NBT_DATA-1:0]           o_rd_data;
    logic                          o_rd_valid;

    modport master (
        output i_ch_data, i_ch_valid, i_rd_en, i_rd_adrs,
        input  o_rd_data, o_rd_valid
    );

    modport slave (
        input  i_ch_data, i_ch_valid, i_rd_en, i_rd_adrs,
        output o_rd_data, o_rd_valid
    );
endinterface

// File: rtl/log_ram.sv
// rtl/log_ram.sv - simple dual-port capture buffer with registered read
module log_ram #(
    parameter int NBT_DATA  = 32,
    parameter int RAM_DEPTH = 32768
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [$clog2(RAM_DEPTH)-1:0] wr_adrs,
    input  logic [NBT_DATA-1:0]          wr_data,
    input  logic                         rd_en,
    input  logic [$clog2(RAM_DEPTH)-1:0] rd_adrs,
    output logic [NBT_DATA-1:0]          rd_data
);
    logic [NBT_DATA-1:0] mem [RAM_DEPTH];

    // Write port; the array itself is never reset so captured data survives reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_adrs] <= wr_data;
        end
    end

    // Registered read; holds the last value until the next read, only the output register resets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_adrs];
        end
    end
endmodule

// File: rtl/log_capture_ctrl.sv
// rtl/log_capture_ctrl.sv - pre/post trigger capture FSM; define LOG_CAPTURE_LEVEL_TRIG_EN for the level trigger
module log_capture_ctrl
    import log_capture_pkg::*;
#(
    parameter int NBT_DATA  = NBT_DATA_DEF,
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int RAM_DEPTH = RAM_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         i_reset,
    log_capture_ctrl_if.slave            bus,
    input  logic [$clog2(NUM_CH)-1:0]    i_ch_sel,
    input  logic [7:0]                   i_decim,
    input  logic [$clog2(RAM_DEPTH)-1:0] i_pretrig,
    input  logic                         i_arm,
    input  logic                         i_abort,
    input  logic                         i_trig_ext,
    input  logic [NBT_DATA-1:0]          i_trig_level,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [2:0]                   o_state,
    output logic [$clog2(RAM_DEPTH)-1:0] o_trig_adrs
);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam int CW = $clog2(NUM_CH);

    state_t              state_q, state_d;
    logic [CW-1:0]       ch_sel_q;
    logic [7:0]          decim_q;
    logic [7:0]          dec_cnt_q;
    logic [AW-1:0]       pretrig_q;
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       cnt_q;
    logic [AW-1:0]       trig_adrs_q;
    logic                done_q;
    logic                rd_valid_q;

    logic [NBT_DATA-1:0] sample;
    logic                collecting;
    logic                store;
    logic                level_hit;
    logic                trig_hit;
    logic                arm_accept;
    logic                rd_accept;
    logic [AW-1:0]       post_len;
    logic [AW-1:0]       rd_phys;

    assign sample = bus.i_ch_data[int'(ch_sel_q)*NBT_DATA +: NBT_DATA];

    // With pretrig=0 the PRE state lasts one cycle and stores nothing, so the decimator stays put.
    assign collecting = is_capturing(state_q) && !((state_q == PRE) && (pretrig_q == '0));
    assign store      = collecting && bus.i_ch_valid && (dec_cnt_q == 8'd0);

`ifdef LOG_CAPTURE_LEVEL_TRIG_EN
    assign level_hit = $signed(sample) > $signed(i_trig_level);
`else
    logic unused_trig_level;
    assign unused_trig_level = ^i_trig_level;
    assign level_hit = 1'b0;
`endif

    assign trig_hit   = store && (state_q == ARMED) && (i_trig_ext || level_hit);
    assign arm_accept = i_arm && !i_abort && ((state_q == IDLE) || (state_q == DONE));
    assign post_len   = AW'(RAM_DEPTH - 1) - pretrig_q;
    assign rd_accept  = bus.i_rd_en && (state_q == DONE);
    assign rd_phys    = trig_adrs_q - pretrig_q + bus.i_rd_adrs;

    // State register.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other request.
    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (i_arm) state_d = PRE;
                PRE: begin
                    if ((pretrig_q == '0) || (store && (cnt_q == pretrig_q - AW'(1)))) begin
                        state_d = ARMED;
                    end
                end
                ARMED: if (trig_hit) state_d = POST;
                POST: begin
                    if ((post_len == '0) || (store && (cnt_q == post_len - AW'(1)))) begin
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Capture datapath: configuration latch, decimator, write pointer, phase counter, trigger address.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            ch_sel_q    <= '0;
            decim_q     <= '0;
            pretrig_q   <= '0;
            dec_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            trig_adrs_q <= '0;
            done_q      <= 1'b0;
        end else if (arm_accept) begin
            ch_sel_q  <= i_ch_sel;
            decim_q   <= i_decim;
            pretrig_q <= i_pretrig;
            dec_cnt_q <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else if (i_abort) begin
            done_q <= 1'b0;
        end else if (collecting) begin
            if (bus.i_ch_valid) begin
                dec_cnt_q <= (dec_cnt_q == decim_q) ? 8'd0 : dec_cnt_q + 8'd1;
            end
            if (store) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (store) begin
                cnt_q <= cnt_q + AW'(1);
            end
            if (trig_hit) begin
                trig_adrs_q <= wr_ptr_q;
            end
            if ((state_q == POST) && (state_d == DONE)) begin
                done_q <= 1'b1;
            end
        end else if ((state_q == POST) && (state_d == DONE)) begin
            done_q <= 1'b1;
        end
    end

    // Read valid follows an accepted read by exactly one cycle.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
        end
    end

    log_ram #(
        .NBT_DATA  (NBT_DATA),
        .RAM_DEPTH (RAM_DEPTH)
    ) u_log_ram (
        .clk     (clk),
        .rst_n   (i_reset),
        .wr_en   (store),
        .wr_adrs (wr_ptr_q),
        .wr_data (sample),
        .rd_en   (rd_accept),
        .rd_adrs (rd_phys),
        .rd_data (bus.o_rd_data)
    );

    assign bus.o_rd_valid = rd_valid_q;
    assign o_busy         = is_capturing(state_q);
    assign o_done         = done_q;
    assign o_state        = state_q;
    assign o_trig_adrs    = trig_adrs_q;
endmodule

// File: tb/tb_log_capture_ctrl.sv
// tb/tb_log_capture_ctrl.sv - self-checking bench for log_capture_ctrl with a sample-list reference model
module tb_log_capture_ctrl;
    localparam int NBT   = 32;
    localparam int NCH   = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic            clk = 1'b0;
    logic            i_reset = 1'b0;
    logic [1:0]      i_ch_sel = '0;
    logic [7:0]      i_decim = '0;
    logic [AW-1:0]   i_pretrig = '0;
    logic            i_arm = 1'b0;
    logic            i_abort = 1'b0;
    logic            i_trig_ext = 1'b0;
    logic [NBT-1:0]  i_trig_level = 32'h7fff_ffff;
    logic            o_busy;
    logic            o_done;
    logic [2:0]      o_state;
    logic [AW-1:0]   o_trig_adrs;

    int checks = 0;
    int errors = 0;

    int val_q[$];
    bit ext_q[$];
    int stored[$];
    bit sext[$];

    always #5 clk = ~clk;

    log_capture_ctrl_if #(.NBT_DATA(NBT), .NUM_CH(NCH), .RAM_DEPTH(DEPTH)) bus ();

    log_capture_ctrl #(.NBT_DATA(NBT), .NUM_CH(NCH), .RAM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .bus          (bus),
        .i_ch_sel     (i_ch_sel),
        .i_decim      (i_decim),
        .i_pretrig    (i_pretrig),
        .i_arm        (i_arm),
        .i_abort      (i_abort),
        .i_trig_ext   (i_trig_ext),
        .i_trig_level (i_trig_level),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_state      (o_state),
        .o_trig_adrs  (o_trig_adrs)
    );

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.i_ch_valid = 1'b0;
            bus.i_rd_en    = 1'b0;
            i_arm          = 1'b0;
            i_abort        = 1'b0;
            i_trig_ext     = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_check(input int l, input logic [NBT-1:0] exp, input string nm);
        logic [NBT-1:0] first;
        @(negedge clk);
        bus.i_rd_en   = 1'b1;
        bus.i_rd_adrs = AW'(l);
        @(posedge clk);
        #1;
        first = bus.o_rd_data;
        checks++;
        if (bus.o_rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s rd_valid L=%0d: got %b want 1", nm, l, bus.o_rd_valid);
        end
        checks++;
        if (first !== exp) begin
            errors++;
            $display("FAIL %s rd_data L=%0d: got %0d want %0d", nm, l, first, exp);
        end
        @(negedge clk);
        bus.i_rd_en = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.o_rd_valid !== 1'b0 || bus.o_rd_data !== exp) begin
            errors++;
            $display("FAIL %s rd_hold L=%0d: got valid %b data %0d want 0 / %0d", nm, l,
                     bus.o_rd_valid, bus.o_rd_data, exp);
        end
    endtask

    // Arms a capture, streams a ramp on channel ch with the external trigger raised once the
    // ramp reaches trig_val, then checks DONE status and every logical read against the model.
    task automatic run_capture(input int pre, input int dec, input int ch, input int start,
                               input int trig_val, input bit rand_valid, input bit stop_post,
                               input string nm, output int t_out);
        int v;
        bit reached;
        bit vld;
        bit hit;
        int t;
        int order[16];
        logic [NCH*NBT-1:0] d;
        v = start;
        reached = 1'b0;
        t_out = -1;
        val_q.delete();
        ext_q.delete();
        @(negedge clk);
        i_ch_sel       = 2'(ch);
        i_decim        = 8'(dec);
        i_pretrig      = AW'(pre);
        i_arm          = 1'b1;
        bus.i_ch_valid = 1'b0;
        i_trig_ext     = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (o_state !== 3'd1 || o_busy !== 1'b1 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL %s arm: got state %0d busy %b done %b want 1 1 0", nm, o_state, o_busy, o_done);
        end
        @(negedge clk);
        i_arm = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            vld = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            d = {$urandom, $urandom, $urandom, $urandom};
            d[ch*NBT +: NBT] = NBT'(v);
            bus.i_ch_data  = d;
            bus.i_ch_valid = vld;
            i_trig_ext     = (v >= trig_val);
            if (vld) begin
                val_q.push_back(v);
                ext_q.push_back(v >= trig_val);
                v++;
            end
            @(posedge clk);
            #1;
            if (stop_post && o_state == 3'd3) begin
                reached = 1'b1;
                break;
            end
            if (!stop_post && o_done === 1'b1) begin
                reached = 1'b1;
                break;
            end
        end
        bus.i_ch_valid = 1'b0;
        i_trig_ext     = 1'b0;
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL %s timeout: got state %0d want %0d", nm, o_state, stop_post ? 3 : 4);
            return;
        end
        if (stop_post) return;

        stored.delete();
        sext.delete();
        for (int k = 0; k < val_q.size(); k++) begin
            if (k % (dec + 1) == 0) begin
                stored.push_back(val_q[k]);
                sext.push_back(ext_q[k]);
            end
        end
        t = -1;
        for (int p = pre; p < stored.size(); p++) begin
            hit = sext[p];
`ifdef LOG_CAPTURE_LEVEL_TRIG_EN
            if ($signed(NBT'(stored[p])) > $signed(i_trig_level)) hit = 1'b1;
`endif
            if (hit) begin
                t = p;
                break;
            end
        end
        checks++;
        if (t < 0) begin
            errors++;
            $display("FAIL %s trigger: got done without trigger, stored %0d", nm, stored.size());
            return;
        end
        t_out = t;
        checks++;
        if (stored.size() != t + DEPTH - pre) begin
            errors++;
            $display("FAIL %s done_count: got %0d stored want %0d", nm, stored.size(), t + DEPTH - pre);
        end
        checks++;
        if (o_trig_adrs !== AW'(t % DEPTH)) begin
            errors++;
            $display("FAIL %s trig_adrs: got %0d want %0d", nm, o_trig_adrs, t % DEPTH);
        end
        checks++;
        if (o_state !== 3'd4 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_state: got state %0d busy %b want 4 0", nm, o_state, o_busy);
        end
        for (int i = 0; i < 16; i++) order[i] = i;
        for (int i = 15; i > 0; i--) begin
            int j;
            int tmp;
            j = $urandom_range(0, i);
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 16; i++) begin
            read_check(order[i], NBT'(stored[t - pre + order[i]]), nm);
        end
    endtask

    task automatic check_reset_values(input string nm);
        checks++;
        if (o_state !== 3'd0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL %s status: got state %0d busy %b done %b want 0 0 0", nm, o_state, o_busy, o_done);
        end
        checks++;
        if (bus.o_rd_valid !== 1'b0 || bus.o_rd_data !== '0 || o_trig_adrs !== '0) begin
            errors++;
            $display("FAIL %s outputs: got rd_valid %b rd_data %0d trig_adrs %0d want 0 0 0",
                     nm, bus.o_rd_valid, bus.o_rd_data, o_trig_adrs);
        end
    endtask

    task automatic test_reset();
        bus.i_ch_data  = '0;
        bus.i_ch_valid = 1'b0;
        bus.i_rd_en    = 1'b0;
        bus.i_rd_adrs  = '0;
        i_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        i_reset = 1'b1;
        idle_cycles(2);
        check_reset_values("post_reset_idle");
    endtask

    task automatic test_ramp_basic();
        int t;
        run_capture(4, 0, 2, 0, 20, 1'b0, 1'b0, "ramp", t);
        checks++;
        if (t != 20 || o_trig_adrs !== 4'd4) begin
            errors++;
            $display("FAIL ramp trig_sample: got t %0d adrs %0d want 20 4", t, o_trig_adrs);
        end
    endtask

    task automatic test_decim();
        int t;
        run_capture(3, 2, 1, 7, 40, 1'b0, 1'b0, "decim", t);
        checks++;
        if (stored.size() < 2 || stored[1] - stored[0] != 3) begin
            errors++;
            $display("FAIL decim step: got %0d want 3", stored.size() < 2 ? -1 : stored[1] - stored[0]);
        end
    endtask

    task automatic test_pretrig_zero();
        int t;
        run_capture(0, 0, 0, 50, 50, 1'b0, 1'b0, "pre0", t);
        checks++;
        if (t != 0 || stored.size() != 16) begin
            errors++;
            $display("FAIL pre0 first_sample: got t %0d stored %0d want 0 16", t, stored.size());
        end
    endtask

    task automatic test_trig_in_pre();
        int t;
        run_capture(6, 0, 3, 0, 0, 1'b0, 1'b0, "trig_pre", t);
        checks++;
        if (o_trig_adrs !== 4'd6) begin
            errors++;
            $display("FAIL trig_pre adrs: got %0d want 6", o_trig_adrs);
        end
        @(negedge clk);
        i_arm   = 1'b1;
        i_abort = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (o_state !== 3'd0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_arm: got state %0d busy %b done %b want 0 0 0", o_state, o_busy, o_done);
        end
        @(negedge clk);
        i_arm         = 1'b0;
        i_abort       = 1'b0;
        bus.i_rd_en   = 1'b1;
        bus.i_rd_adrs = 4'd3;
        @(posedge clk);
        #1;
        checks++;
        if (bus.o_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_idle: got rd_valid %b want 0", bus.o_rd_valid);
        end
        idle_cycles(1);
    endtask

    task automatic test_reset_in_post();
        int t;
        run_capture(5, 1, 2, 0, 10, 1'b0, 1'b1, "post_stop", t);
        #2;
        i_reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b1;
        idle_cycles(1);
        run_capture(2, 0, 1, 7, 30, 1'b1, 1'b0, "rearm", t);
    endtask

    task automatic test_level();
        int t;
        i_trig_level = 32'd10;
`ifdef LOG_CAPTURE_LEVEL_TRIG_EN
        run_capture(4, 0, 0, 0, 32'h4000_0000, 1'b0, 1'b0, "level", t);
        checks++;
        if (o_trig_adrs !== 4'd11) begin
            errors++;
            $display("FAIL level adrs: got %0d want 11", o_trig_adrs);
        end
`else
        run_capture(4, 0, 0, 0, 25, 1'b0, 1'b0, "level", t);
        checks++;
        if (o_trig_adrs !== 4'd9) begin
            errors++;
            $display("FAIL level adrs: got %0d want 9", o_trig_adrs);
        end
`endif
        i_trig_level = 32'h7fff_ffff;
    endtask

    task automatic test_random();
        int t;
        int start;
        for (int n = 0; n < 4; n++) begin
            start = $urandom_range(0, 200);
            run_capture($urandom_range(0, 10), $urandom_range(0, 3), $urandom_range(0, 3), start,
                        start + $urandom_range(0, 40), 1'b1, 1'b0, "random", t);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_basic();
        test_decim();
        test_pretrig_zero();
        test_trig_in_pre();
        test_reset_in_post();
        test_level();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
